// File: rtl/mdclcg_pkg.sv
// Shared types and defaults for the modified dual-CLCG keystream sink.
package mdclcg_pkg;

  localparam int MDCLCG_WORD_W    = 16;
  localparam int MDCLCG_RCT_LIMIT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // Width needed to hold a run count of 0..limit inclusive.
  function automatic int run_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mdclcg_rct_monitor.sv
// Repetition-count health test: tracks the run of identical accepted bits and
// flags the bit that brings the run up to RCT_LIMIT.
module mdclcg_rct_monitor
  import mdclcg_pkg::*;
#(
  parameter int RCT_LIMIT = MDCLCG_RCT_LIMIT
) (
  input  logic clk1,
  input  logic rst,
  input  logic bit_in,
  input  logic accept,
  input  logic clear,
  output logic trip
);

  localparam int RUN_W = run_cnt_width(RCT_LIMIT);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RCT_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

  logic             r_last;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_next;

  // A zero run count marks "no bit seen since reset/clear".
  always_comb begin
    w_run_next = r_run;
    if ((r_run == '0) || (bit_in != r_last)) begin
      w_run_next = RUN_ONE;
    end else if (r_run != RUN_LIMIT) begin
      w_run_next = r_run + 1'b1;
    end
  end

  assign trip = accept && (w_run_next == RUN_LIMIT);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_run  <= '0;
      r_last <= 1'b0;
    end else if (clear) begin
      r_run  <= '0;
      r_last <= 1'b0;
    end else if (accept) begin
      r_run  <= w_run_next;
      r_last <= bit_in;
    end
  end

endmodule

// File: rtl/mdclcg_bit_packer.sv
// Packs the serial keystream MSB-first into words behind a valid/ready holding
// register, and blocks delivery once the repetition-count test trips.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | not packing; partial word and run count retained
//   ST_COLLECT | accepting qualified bits into the shift register
//   ST_FAULT   | health test tripped; bits ignored until clear or reset
module mdclcg_bit_packer
  import mdclcg_pkg::*;
#(
  parameter int WIDTH     = MDCLCG_WORD_W,
  parameter int RCT_LIMIT = MDCLCG_RCT_LIMIT
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
  output logic                     rct_fail,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic             r_overflow;
  logic             r_rct_fail;

  logic             w_accept;
  logic             w_trip;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_complete;
  logic             w_xfer;
  logic             w_load;
  logic             w_drop;

  assign w_accept     = (r_state == ST_COLLECT) && enable && bit_valid && !clear;
  assign w_shift_next = {r_shift[WIDTH-2:0], bit_in};

  mdclcg_rct_monitor #(
    .RCT_LIMIT (RCT_LIMIT)
  ) u_rct_monitor (
    .clk1   (clk1),
    .rst    (rst),
    .bit_in (bit_in),
    .accept (w_accept),
    .clear  (clear),
    .trip   (w_trip)
  );

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            w_state_next = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_trip) begin
            w_state_next = ST_FAULT;
          end else if (!enable) begin
            w_state_next = ST_IDLE;
          end
        end
        ST_FAULT: begin
          w_state_next = ST_FAULT;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // A tripping bit never completes a word, even on the WIDTH-th position.
  always_comb begin
    w_complete = w_accept && (r_bit_cnt == LAST_IDX) && !w_trip;
    w_xfer     = r_word_valid && word_ready;
    w_load     = w_complete && (!r_word_valid || word_ready);
    w_drop     = w_complete && r_word_valid && !word_ready;
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_rct_fail   <= 1'b0;
    end else if (clear) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_rct_fail   <= 1'b0;
    end else if (w_trip) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_rct_fail   <= 1'b1;
    end else begin
      if (w_accept) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= (r_bit_cnt == LAST_IDX) ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_load) begin
        r_word       <= w_shift_next;
        r_word_valid <= 1'b1;
      end else if (w_xfer) begin
        r_word_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_word_valid;
  assign overflow   = r_overflow;
  assign rct_fail   = r_rct_fail;
  assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_mdclcg_bit_packer.sv
// Scoreboard bench for the keystream bit packer: a queue-based reference model
// predicts delivered words and flags; a negedge monitor compares against the DUT.
module tb_mdclcg_bit_packer;

  localparam int W   = 16;
  localparam int LIM = 32;

  logic                 clk1 = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 clear;
  logic                 bit_in;
  logic                 bit_valid;
  logic [W-1:0]         word_out;
  logic                 word_valid;
  logic                 word_ready;
  logic                 overflow;
  logic                 rct_fail;
  logic [$clog2(W)-1:0] bit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  bit           m_active;
  bit           m_fault;
  bit           m_ovf;
  int           m_run;
  bit           m_last;
  bit           m_bits[$];
  logic [W-1:0] sb_q[$];

  mdclcg_bit_packer #(
    .WIDTH     (W),
    .RCT_LIMIT (LIM)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .rct_fail   (rct_fail),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_active = 0;
    m_fault  = 0;
    m_ovf    = 0;
    m_run    = 0;
    m_last   = 0;
    m_bits.delete();
    sb_q.delete();
  endtask

  // Drive one cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic b, input logic rdy, input logic en, input logic clr);
    bit           acc, trip, comp, push;
    int           run_new;
    logic [W-1:0] w;
    bit_valid  = v;
    bit_in     = b;
    word_ready = rdy;
    enable     = en;
    clear      = clr;
    acc = m_active && !m_fault && en && v && !clr;
    trip = 0; comp = 0; push = 0; run_new = m_run; w = '0;
    if (acc) begin
      if (m_run == 0 || b != m_last) run_new = 1;
      else run_new = (m_run < LIM) ? m_run + 1 : LIM;
      trip = (run_new == LIM);
      comp = (m_bits.size() == W - 1);
      if (comp) begin
        foreach (m_bits[i]) w = w * 2 + W'(m_bits[i]);
        w = w * 2 + W'(b);
      end
      push = comp && !trip && (sb_q.size() == 0 || rdy);
    end
    @(posedge clk1);
    #1;
    if (clr) begin
      reset_model();
    end else begin
      if (acc) begin
        m_run  = run_new;
        m_last = b;
        if (trip) begin
          m_fault = 1;
          m_bits.delete();
          sb_q.delete();
        end else if (comp) begin
          m_bits.delete();
          if (push) sb_q.push_back(w);
          else m_ovf = 1;
        end else begin
          m_bits.push_back(b);
        end
      end
      m_active = en && !m_fault;
    end
  endtask

  task automatic send_bits(input logic [W-1:0] word, input int first, input int last,
                           input logic rdy, input logic rdy_last, input int maxgap);
    for (int i = first; i <= last; i++) begin
      int gap = $urandom_range(0, maxgap);
      repeat (gap) step(1'b0, 1'b0, rdy, 1'b1, 1'b0);
      step(1'b1, word[W-1-i], (i == last) ? rdy_last : rdy, 1'b1, 1'b0);
    end
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: per-cycle flag checks and scoreboard pops on handshake.
  always @(negedge clk1) begin
    if (rst) begin
      chk("mon_valid", word_valid, sb_q.size() != 0);
      chk("mon_bit_cnt", bit_cnt, m_bits.size());
      chk("mon_overflow", overflow, m_ovf);
      chk("mon_rct_fail", rct_fail, m_fault);
      if (word_valid && sb_q.size() != 0) begin
        chk("mon_word_out", word_out, sb_q[0]);
        if (word_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; enable = 1'b0; clear = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    reset_model();
    repeat (3) @(posedge clk1);
    #1;
    chk("rst_word_out", word_out, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rct_fail", rct_fail, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Basic packing
    send_bits(16'hA5C3, 0, W - 1, 1'b1, 1'b1, 3);
    chk("basic_valid", word_valid, 1);
    chk("basic_word", word_out, 16'hA5C3);
    chk("basic_ovf", overflow, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("basic_one_cycle", word_valid, 0);

    // Back-pressure
    send_bits(16'h1234, 0, W - 1, 1'b0, 1'b0, 2);
    send_bits(16'h0F0F, 0, W - 1, 1'b0, 1'b0, 2);
    chk("bp_ovf", overflow, 1);
    chk("bp_word", word_out, 16'h1234);
    chk("bp_valid", word_valid, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bp_drained", word_valid, 0);
    do_clear();
    chk("clr_ovf", overflow, 0);

    // Simultaneous drain and completion
    send_bits(16'h1234, 0, W - 1, 1'b0, 1'b0, 1);
    send_bits(16'hBEEF, 0, W - 1, 1'b0, 1'b1, 2);
    chk("dc_valid", word_valid, 1);
    chk("dc_word", word_out, 16'hBEEF);
    chk("dc_ovf", overflow, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Health test
    do_clear();
    for (int i = 0; i < LIM - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rct_not_yet", rct_fail, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rct_trip", rct_fail, 1);
    chk("rct_valid", word_valid, 0);
    chk("rct_cnt", bit_cnt, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rct_ignored", bit_cnt, 0);
    do_clear();
    chk("rct_clr_fail", rct_fail, 0);
    chk("rct_clr_ovf", overflow, 0);
    send_bits(16'hA5C3, 0, W - 1, 1'b1, 1'b1, 1);
    chk("rct_after_word", word_out, 16'hA5C3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Enable gating
    send_bits(16'hC3A5, 0, 4, 1'b1, 1'b1, 1);
    for (int i = 0; i < 6; i++) step(i[0], 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    chk("en_hold_cnt", bit_cnt, 5);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(16'hC3A5, 5, W - 1, 1'b1, 1'b1, 1);
    chk("en_word", word_out, 16'hC3A5);
    chk("en_valid", word_valid, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Async reset mid-word
    do_clear();
    send_bits(16'h5A5A, 0, W - 1, 1'b0, 1'b0, 1);
    send_bits(16'h3C00, 0, 6, 1'b0, 1'b0, 1);
    chk("mid_pre_cnt", bit_cnt, 7);
    chk("mid_pre_valid", word_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_word_out", word_out, 0);
    chk("mid_word_valid", word_valid, 0);
    chk("mid_overflow", overflow, 0);
    chk("mid_rct_fail", rct_fail, 0);
    chk("mid_bit_cnt", bit_cnt, 0);
    reset_model();
    #2;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with occasional stuck runs, enable drops and clears
    begin
      bit stuck = 0;
      bit level = 0;
      for (int c = 0; c < 4000; c++) begin
        logic v, b, rdy, en, clr;
        if ($urandom_range(0, 149) == 0) begin
          stuck = ($urandom_range(0, 2) == 0);
          level = 1'($urandom_range(0, 1));
        end
        v   = ($urandom_range(0, 3) != 0);
        b   = stuck ? level : 1'($urandom_range(0, 1));
        rdy = ($urandom_range(0, 2) != 0);
        en  = ($urandom_range(0, 19) != 0);
        clr = ($urandom_range(0, 399) == 0) || (m_fault && $urandom_range(0, 29) == 0);
        step(v, b, rdy, en, clr);
      end
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("final_drained", word_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdclcg_bit_packer.md
# mdclcg_bit_packer

Stream-side sink for the modified dual-CLCG keystream. Accepts the serial `z_i` bit stream one qualified bit at a time, packs it MSB-first into WIDTH-bit words, and presents them on a valid/ready word interface to downstream logic (bus bridge, FIFO, cipher datapath). It also runs an online repetition-count health test on the raw bits and blocks word delivery once the generator output is stuck.

## Interface
- `WIDTH`, 16: packed word width; at least 2.
- `RCT_LIMIT`, 32: identical consecutive bits that trip the health test; at least 2.
- `clk1`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  packing enable; when low, incoming bits are ignored and state is held.
- `clear`  in  1  synchronous clear of packer, health test, sticky flags and holding register.
- `bit_in`  in  1  keystream bit (`z_i` of the generator).
- `bit_valid`  in  1  `bit_in` is a new bit this cycle.
- `word_out`  out  WIDTH  packed word; bit WIDTH-1 is the first bit received.
- `word_valid`  out  1  `word_out` holds an undelivered word.
- `word_ready`  in  1  downstream accepts `word_out` this cycle.
- `overflow`  out  1  sticky; a completed word was dropped because the holding register was full.
- `rct_fail`  out  1  sticky; the repetition-count test tripped.
- `bit_cnt`  out  $clog2(WIDTH)  bits currently in the partial word.

## Operation
- **Reset values (async, `rst`=0):** `word_out`=0, `word_valid`=0, `overflow`=0, `rct_fail`=0, `bit_cnt`=0. Run counter is 0 and last-bit register is 0. FSM is in IDLE.
- **FSM states:** IDLE, COLLECT, FAULT.
  - IDLE→COLLECT when `enable`=1.
  - COLLECT→IDLE when `enable`=0. The partial word and run count are retained and packing resumes where it left off.
  - COLLECT→FAULT when the run counter reaches RCT_LIMIT.
  - Any state→IDLE on `clear`.
  - FAULT is left only by `clear` or `rst`.
- **Bit acceptance:** a bit is accepted when state is COLLECT, `bit_valid`=1 and `clear`=0. The bit shifts into the LSB of the shift register and `bit_cnt` increments.
- **Word completion:** completion occurs on the WIDTH-th accepted bit. `bit_cnt` wraps to 0.
  - If the holding register is empty, or is being drained this same cycle, the completed word loads into `word_out` and `word_valid`=1.
  - Otherwise the completed word is discarded, `overflow` sets, and `word_out` is unchanged.
- **Word handshake:** a transfer occurs when `word_valid`=1 and `word_ready`=1.
  - `word_out` stays stable while `word_valid`=1 and `word_ready`=0.
  - `word_valid` does not depend combinationally on `word_ready`.
- **Repetition-count test:**
  - The first accepted bit after reset or clear sets the run counter to 1.
  - Each later accepted bit equal to the previous accepted bit increments the counter, saturating at RCT_LIMIT. A differing bit resets it to 1.
  - Reaching RCT_LIMIT sets `rct_fail` and enters FAULT.
  - On entering FAULT, `word_valid` is forced to 0, the held word is discarded, and the partial word is discarded with `bit_cnt`=0.
  - In FAULT all bits are ignored.
- **Tripping bit that also completes a word:** the fault takes priority and the word is not delivered.
- **Clear:** has priority over everything in the same cycle. A concurrent bit is discarded, and a concurrent handshake still counts as a transfer for downstream while the register empties. After clear, all outputs equal their reset values.
- **`enable`=0 with a held word:** the held word remains deliverable via the handshake.

## Timing
- Latency: `word_valid` rises on the edge that accepts the WIDTH-th bit, so it is visible the cycle after that bit is presented.
- Sustained throughput is one bit per cycle, so one word per WIDTH cycles with `word_ready`=1. There are no bubbles.
- `rct_fail` and the `word_valid` drop take effect on the edge accepting the tripping bit.
- `overflow` sets on the edge of the dropped completion.
- The registered reset release is asynchronous assert; deassertion is used as-is because the synchronizer lives at the top level.

## Structure
- Shared package `mdclcg_pkg` holds:
  - the state enum (IDLE, COLLECT, FAULT);
  - default constants `MDCLCG_WORD_W`=16 and `MDCLCG_RCT_LIMIT`=32.
- One sub-module, `mdclcg_rct_monitor`, owns the last-bit register and the saturating run counter.
  - Inputs: `bit`, `accept`, `clear`.
  - Output: `trip`.
- The packer, holding register and FSM live in the top module.

## Test plan
- **Reset:** assert `rst` mid-word (`bit_cnt`=7, `word_valid`=1) → all outputs 0 immediately, no clock needed.
- **Basic packing:** `word_ready`=1, feed 16'hA5C3 MSB-first with `bit_valid` gaps of 0–3 cycles → `word_valid` for exactly one cycle, `word_out`=16'hA5C3, `overflow`=0.
- **Back-pressure:** `word_ready`=0, feed 16'h1234 then 16'h0F0F → `overflow`=1 at the 32nd bit, `word_out` stays 16'h1234. Then raise `word_ready` → one transfer of 16'h1234.
- **Simultaneous drain and completion:** `word_out`=16'h1234 held, `word_ready`=1 on the same cycle the 16th bit of 16'hBEEF arrives → `word_valid` stays 1, `word_out`=16'hBEEF, `overflow`=0.
- **Health test:** feed 31 zeros → no fault. 32nd zero → `rct_fail`=1, `word_valid`=0, and further bits leave `bit_cnt`=0. Pulse `clear` → flags 0, then 16'hA5C3 packs correctly.
- **Enable gating:** deassert `enable` after 5 bits of 16'hC3A5 while toggling `bit_valid` → `bit_cnt` holds 5. Reassert and send the remaining 11 bits → `word_out`=16'hC3A5.
